// File: rtl/mod_add_sub_pipe.sv
// Two-stage pipelined modular add/sub/dbl/neg with valid/ready handshakes and a pass-through tag.
// Optional operand range checking and the err port are enabled by MOD_ADD_SUB_RANGE_CHECK_EN.
module mod_add_sub_pipe #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out
`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpDbl = 2'b10;
  localparam logic [1:0] OpNeg = 2'b11;

  // Handshake and valid bits
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_move;
  logic s1_load;
  logic s2_load;

  // Stage-1 raw arithmetic
  logic [WIDTH:0]   sum_w;
  logic [WIDTH+1:0] corr_w;
  logic             zero_w;

  logic [WIDTH:0]   s1_sum_q;
  logic [WIDTH+1:0] s1_corr_q;
  logic [1:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s1_zero_q;

  // Stage-2 selection
  logic [WIDTH-1:0] sel_w;
  logic [WIDTH-1:0] s2_result_q;
  logic [TAG_W-1:0] s2_tag_q;

  // Bit WIDTH of the signed correction never affects the truncated result.
  logic unused_corr_bit;
  assign unused_corr_bit = s1_corr_q[WIDTH];

  assign s1_move  = !s2_valid_q || out_ready;
  assign in_ready = rst_n && (!s1_valid_q || s1_move);
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_move && s1_valid_q;

  always_comb begin
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s2_valid_d = s1_move ? s1_valid_q : s2_valid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Raw value plus a single candidate correction; operands below p need at most one.
  always_comb begin
    sum_w  = '0;
    corr_w = '0;
    unique case (op)
      OpAdd: begin
        sum_w  = {1'b0, a} + {1'b0, b};
        corr_w = {1'b0, sum_w} - {2'b00, p};
      end
      OpSub: begin
        sum_w  = {1'b0, a} - {1'b0, b};
        corr_w = {sum_w[WIDTH], sum_w} + {2'b00, p};
      end
      OpDbl: begin
        sum_w  = {a, 1'b0};
        corr_w = {1'b0, sum_w} - {2'b00, p};
      end
      OpNeg: begin
        sum_w  = {1'b0, p} - {1'b0, a};
        corr_w = '0;
      end
    endcase
  end

  assign zero_w = (a == '0);

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_sum_q  <= sum_w;
      s1_corr_q <= corr_w;
      s1_op_q   <= op;
      s1_tag_q  <= tag_in;
      s1_zero_q <= zero_w;
    end
  end

  always_comb begin
    sel_w = '0;
    unique case (s1_op_q)
      OpAdd, OpDbl: sel_w = s1_corr_q[WIDTH+1] ? s1_sum_q[WIDTH-1:0] : s1_corr_q[WIDTH-1:0];
      OpSub:        sel_w = s1_sum_q[WIDTH] ? s1_corr_q[WIDTH-1:0] : s1_sum_q[WIDTH-1:0];
      OpNeg:        sel_w = s1_zero_q ? '0 : s1_sum_q[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (s2_load) begin
      s2_result_q <= sel_w;
      s2_tag_q    <= s1_tag_q;
    end
  end

  // Data registers are not reset, so outputs are masked while the stage is empty.
  assign out_valid = s2_valid_q;
  assign result    = s2_valid_q ? s2_result_q : '0;
  assign tag_out   = s2_valid_q ? s2_tag_q : '0;

`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
  logic err_w;
  logic s1_err_q;
  logic s2_err_q;

  assign err_w = (p < WIDTH'(2)) || (a >= p) || (((op == OpAdd) || (op == OpSub)) && (b >= p));

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_err_q <= err_w;
    end
    if (s2_load) begin
      s2_err_q <= s1_err_q;
    end
  end

  assign err = s2_valid_q && s2_err_q;
`endif

endmodule

// File: tb/tb_mod_add_sub_pipe.sv
// Randomised bench for mod_add_sub_pipe: scoreboard of plain modular arithmetic, per-cycle
// handshake expectations, directed vectors, backpressure and mid-flight reset.
module tb_mod_add_sub_pipe;

  localparam int W  = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  p = W'(2);
  logic [TW-1:0] tag_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic [TW-1:0] tag_out;
`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
  logic          err;
  logic          last_err = 1'b0;
`endif

  always #5 clk = ~clk;

  mod_add_sub_pipe #(
    .WIDTH(W),
    .TAG_W(TW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .p        (p),
    .tag_in   (tag_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .tag_out  (tag_out)
`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
    ,
    .err      (err)
`endif
  );

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic          err;
    int            acc;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           n_out = 0;
  bit           acc_last = 1'b0;
  logic [W-1:0] last_res = '0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    else n_pass++;
  endtask

  // Field arithmetic straight from the definition of a+b, a-b, 2a, -a mod p.
  function automatic logic [W-1:0] ref_mod(input logic [1:0] o, input int x, input int y,
                                           input int m);
    int r;
    case (o)
      2'd0:    r = (x + y) % m;
      2'd1:    r = (x - y + m) % m;
      2'd2:    r = (2 * x) % m;
      default: r = (m - x) % m;
    endcase
    return W'(r);
  endfunction

  function automatic logic ref_err(input logic [1:0] o, input int x, input int y, input int m);
    return (m < 2) || (x >= m) || ((o < 2) && (y >= m));
  endfunction

  // Called once per cycle, 2 time units after the falling edge.
  task automatic monitor();
    exp_t e;
    logic exp_ov;
    logic exp_ir;
    acc_last = 1'b0;
    if (!rst_n) begin
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      sb.delete();
    end else begin
      exp_ov = (sb.size() > 0) && (cyc >= sb[0].acc + 2);
      exp_ir = (sb.size() < 2) || out_ready;
      check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
      check_eq("in_ready", 32'(in_ready), 32'(exp_ir));
      if (out_valid && sb.size() > 0) begin
        e = sb[0];
        if (!e.err) check_eq("result", 32'(result), 32'(e.res));
        check_eq("tag_out", 32'(tag_out), 32'(e.tag));
`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
        check_eq("err", 32'(err), 32'(e.err));
`endif
        if (out_ready) begin
          last_res = result;
`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
          last_err = err;
`endif
          n_out++;
          void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        e.res = ref_mod(op, int'(a), int'(b), int'(p));
        e.tag = tag_in;
        e.err = ref_err(op, int'(a), int'(b), int'(p));
        e.acc = cyc;
        sb.push_back(e);
        acc_last = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    #2;
    monitor();
    @(negedge clk);
  endtask

  task automatic rand_op();
    p      = W'($urandom_range(2, 255));
    a      = W'($urandom_range(0, int'(p) - 1));
    b      = W'($urandom_range(0, int'(p) - 1));
    op     = 2'($urandom_range(0, 3));
    tag_in = TW'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int g;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while (sb.size() > 0 && g < 20) begin
      tick();
      g++;
    end
    check_eq("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Single op into an empty pipe with out_ready high; result lands two cycles later.
  task automatic directed(input logic [1:0] o, input int x, input int y, input int m,
                          input int t, input int exp_res);
    op = o; a = W'(x); b = W'(y); p = W'(m); tag_in = TW'(t);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    check_eq("dir_accept", 32'(acc_last), 32'd1);
    in_valid = 1'b0;
    tick();
    tick();
    check_eq("dir_result", 32'(last_res), 32'(exp_res));
  endtask

  initial begin
    int idx;
    int g;
    int out0;

    @(negedge clk);
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_tag_out", 32'(tag_out), 32'd0);

    directed(2'd0, 200, 100, 251, 1, 49);
    directed(2'd0, 100, 50, 251, 2, 150);
    directed(2'd1, 5, 10, 251, 3, 246);
    directed(2'd1, 10, 10, 251, 4, 0);
    directed(2'd2, 250, 7, 251, 5, 249);
    directed(2'd3, 1, 9, 251, 6, 250);
    directed(2'd3, 0, 3, 251, 7, 0);

    // Streaming: one op per cycle with the consumer always ready.
    out0 = n_out;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rand_op();
      tick();
      check_eq("stream_accept", 32'(acc_last), 32'd1);
    end
    drain();
    check_eq("stream_count", 32'(n_out - out0), 32'd16);

    // Backpressure: four ops offered while the consumer stalls.
    out0      = n_out;
    out_ready = 1'b0;
    idx       = 0;
    rand_op();
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (acc_last) begin
        idx++;
        rand_op();
      end
    end
    check_eq("bp_accepted", 32'(idx), 32'd2);
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    g = 0;
    while (idx < 4 && g < 20) begin
      tick();
      if (acc_last) begin
        idx++;
        rand_op();
      end
      g++;
    end
    check_eq("bp_all_accepted", 32'(idx), 32'd4);
    drain();
    check_eq("bp_count", 32'(n_out - out0), 32'd4);

    // Reset with two ops in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_op();
    tick();
    rand_op();
    tick();
    check_eq("pre_rst_inflight", 32'(sb.size()), 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("post_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
    directed(2'd0, 200, 100, 251, 9, 49);

    // Random traffic with random stalls.
    out0 = n_out;
    idx  = 0;
    for (int k = 0; k < 60; k++) begin
      rand_op();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc_last) idx++;
    end
    drain();
    check_eq("rand_count", 32'(n_out - out0), 32'(idx));

`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
    directed(2'd0, 251, 0, 251, 10, 0);
    check_eq("err_a_ge_p", 32'(last_err), 32'd1);
    directed(2'd0, 250, 250, 251, 11, 249);
    check_eq("err_in_range", 32'(last_err), 32'd0);
    directed(2'd0, 0, 0, 1, 12, 0);
    check_eq("err_p_lt_2", 32'(last_err), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
